// File: rtl/axi_lite_regbank.sv
// ---------------------------------------------------------------------------
// axi_lite_regbank
//   AXI4-Lite slave register bank: NUM_REGS read/write control words, a
//   read-only live status word, a write-1-to-clear interrupt pending word and
//   an interrupt enable word. Unmapped accesses answer SLVERR.
//
//   Word map (index = address >> log2(DATA_WIDTH/8)):
//     0 .. NUM_REGS-1  CTRL     (RW, byte strobes honoured)
//     NUM_REGS         STATUS   (RO, status_i sampled at AR handshake)
//     NUM_REGS+1       IRQ_PEND (W1C)
//     NUM_REGS+2       IRQ_EN   (RW, byte strobes honoured)
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESETN   clock, async-assert active-low reset
//   S_AXI_AW* / W* / B*          write address, data and response channels
//   S_AXI_AR* / R*               read address and data channels
//   ctrl_o     packed control registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   status_i   live status word
//   irq_src_i  per-bit interrupt set requests (level or pulse)
//   irq_o      registered OR of enabled pending bits
// ---------------------------------------------------------------------------
module axi_lite_regbank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 4,
  parameter int                    ADDR_WIDTH = 7,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_o,
  input  logic [DATA_WIDTH-1:0]          status_i,
  input  logic [DATA_WIDTH-1:0]          irq_src_i,
  output logic                           irq_o
);

  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int LSB        = $clog2(STRB_W);
  localparam int IDX_STATUS = NUM_REGS;
  localparam int IDX_PEND   = NUM_REGS + 1;
  localparam int IDX_EN     = NUM_REGS + 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Reset: asserts asynchronously, releases two clocks after S_AXI_ARESETN
  // rises so every flop leaves reset on the same clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_rst_sync <= 2'b00;
    else                r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Write channel holding registers
  logic                  r_aw_held, r_w_held, r_bvalid;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [1:0]            r_bresp;

  // Register file
  logic [DATA_WIDTH-1:0] r_ctrl [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_irq_pend, r_irq_en;
  logic                  r_irq;

  // Read channel
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  assign S_AXI_AWREADY = w_rst_n & ~r_aw_held & ~r_bvalid;
  assign S_AXI_WREADY  = w_rst_n & ~r_w_held  & ~r_bvalid;
  assign S_AXI_ARREADY = w_rst_n & ~r_rvalid;

  logic w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  assign w_aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign w_ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // A channel handshaking this cycle counts as held, so the write commits
  // on the later handshake edge and BVALID appears one cycle after it.
  assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

  logic [ADDR_WIDTH-1:0] w_awaddr;
  logic [DATA_WIDTH-1:0] w_wdata, w_bmask, w_clr;
  logic [STRB_W-1:0]     w_wstrb;
  int                    w_wr_idx, w_rd_idx;
  logic                  w_wr_mapped;

  assign w_awaddr    = r_aw_held ? r_awaddr : S_AXI_AWADDR;
  assign w_wdata     = r_w_held  ? r_wdata  : S_AXI_WDATA;
  assign w_wstrb     = r_w_held  ? r_wstrb  : S_AXI_WSTRB;
  assign w_wr_idx    = int'(w_awaddr[ADDR_WIDTH-1:LSB]);
  assign w_rd_idx    = int'(S_AXI_ARADDR[ADDR_WIDTH-1:LSB]);
  assign w_wr_mapped = w_wr_idx < NUM_REGS + 3;

  always_comb begin
    for (int k = 0; k < STRB_W; k++) w_bmask[k*8 +: 8] = {8{w_wstrb[k]}};
  end

  // W1C mask: only bits with both a 1 in WDATA and their byte strobe set.
  assign w_clr = (w_commit && w_wr_idx == IDX_PEND) ? (w_wdata & w_bmask) : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge S_AXI_ACLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= S_AXI_AWADDR;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= S_AXI_WDATA;
          r_wstrb  <= S_AXI_WSTRB;
        end
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // NOTE: the control words are plain flops feeding ctrl_o, not a RAM, so
  // each entry is reset explicitly to give a defined value after reset.
  always_ff @(posedge S_AXI_ACLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_ctrl[i] <= RESET_VAL;
      r_irq_en   <= '0;
      r_irq_pend <= '0;
      r_irq      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_commit && w_wr_idx == i)
          r_ctrl[i] <= (r_ctrl[i] & ~w_bmask) | (w_wdata & w_bmask);
      end
      if (w_commit && w_wr_idx == IDX_EN)
        r_irq_en <= (r_irq_en & ~w_bmask) | (w_wdata & w_bmask);
      // Set wins over a simultaneous clear of the same bit.
      r_irq_pend <= irq_src_i | (r_irq_pend & ~w_clr);
      r_irq      <= |(r_irq_pend & r_irq_en);
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and infers a latch.
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [1:0]            w_rd_resp;

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    if (w_rd_idx < NUM_REGS) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_rd_idx == i) w_rd_data = r_ctrl[i];
    end else if (w_rd_idx == IDX_STATUS) begin
      w_rd_data = status_i;
    end else if (w_rd_idx == IDX_PEND) begin
      w_rd_data = r_irq_pend;
    end else if (w_rd_idx == IDX_EN) begin
      w_rd_data = r_irq_en;
    end else begin
      w_rd_resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  assign S_AXI_BVALID = r_bvalid;
  assign S_AXI_BRESP  = r_bresp;
  assign S_AXI_RVALID = r_rvalid;
  assign S_AXI_RDATA  = r_rdata;
  assign S_AXI_RRESP  = r_rresp;
  assign irq_o        = r_irq;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
    assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[g];
  end

  // Protection bits and sub-word address bits carry no meaning here.
  logic w_unused;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      w_awaddr[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

endmodule

// File: tb/tb_axi_lite_regbank.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_regbank
//   Directed and randomized AXI4-Lite traffic against axi_lite_regbank with a
//   behavioural register-map model. Inputs change and outputs are observed on
//   the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_regbank;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int AW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [AW-1:0]     S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]        S_AXI_AWPROT, S_AXI_ARPROT;
  logic              S_AXI_AWVALID, S_AXI_AWREADY;
  logic [DW-1:0]     S_AXI_WDATA;
  logic [DW/8-1:0]   S_AXI_WSTRB;
  logic              S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID, S_AXI_BREADY;
  logic              S_AXI_ARVALID, S_AXI_ARREADY;
  logic [DW-1:0]     S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID, S_AXI_RREADY;
  logic [NR*DW-1:0]  ctrl_o;
  logic [DW-1:0]     status_i, irq_src_i;
  logic              irq_o;

  axi_lite_regbank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .RESET_VAL('0)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .ctrl_o(ctrl_o), .status_i(status_i), .irq_src_i(irq_src_i), .irq_o(irq_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_ctrl [NR];
  logic [DW-1:0] m_en, m_pend;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_ctrl[i] = '0;
    m_en   = '0;
    m_pend = '0;
  endtask

  function automatic logic [DW-1:0] byte_mask(input logic [3:0] strb);
    logic [DW-1:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (strb[k]) m[k*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Applies a write to the model and returns the expected BRESP.
  function automatic logic [1:0] model_write(input logic [AW-1:0] addr,
                                             input logic [DW-1:0] data,
                                             input logic [3:0] strb);
    int idx;
    logic [DW-1:0] m;
    idx = int'(addr) / 4;
    m   = byte_mask(strb);
    if (idx < NR) begin
      m_ctrl[idx] = (m_ctrl[idx] & ~m) | (data & m);
      return 2'b00;
    end
    if (idx == NR)     return 2'b00;
    if (idx == NR + 1) begin m_pend = m_pend & ~(data & m); return 2'b00; end
    if (idx == NR + 2) begin m_en = (m_en & ~m) | (data & m); return 2'b00; end
    return 2'b10;
  endfunction

  function automatic void model_read(input logic [AW-1:0] addr,
                                     output logic [DW-1:0] data, output logic [1:0] resp);
    int idx;
    idx  = int'(addr) / 4;
    resp = 2'b00;
    if (idx < NR)           data = m_ctrl[idx];
    else if (idx == NR)     data = status_i;
    else if (idx == NR + 1) data = m_pend;
    else if (idx == NR + 2) data = m_en;
    else begin data = '0; resp = 2'b10; end
  endfunction

  function automatic logic [127:0] model_ctrl();
    logic [127:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_ctrl[i];
    return v;
  endfunction

  // ---------------- bus tasks (entered and left on a falling edge) ----------------
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_hold, output logic [1:0] resp);
    bit aw_done, w_done, aw_f, w_f;
    int cyc, lat;
    logic [1:0] r0;
    aw_done = 0; w_done = 0; cyc = 0; lat = 1;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done) && cyc < 64) begin
      S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AXI_WVALID  = !w_done  && (cyc >= w_dly);
      aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
      w_f  = S_AXI_WVALID  && S_AXI_WREADY;
      @(negedge clk);
      aw_done |= aw_f;
      w_done  |= w_f;
      cyc++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    resp = 2'bxx;
    check("wr_handshake", 128'({aw_done, w_done}), 128'(2'b11));
    if (!(aw_done && w_done)) return;
    while (!S_AXI_BVALID && lat < 20) begin @(negedge clk); lat++; end
    check("b_latency", 128'(lat), 128'(1));
    r0 = S_AXI_BRESP;
    repeat (b_hold) begin
      @(negedge clk);
      check("bvalid_hold", 128'(S_AXI_BVALID), 128'(1'b1));
      check("bresp_hold", 128'(S_AXI_BRESP), 128'(r0));
    end
    S_AXI_BREADY = 1'b1;
    resp = S_AXI_BRESP;
    @(negedge clk);
    S_AXI_BREADY = 1'b0;
    check("bvalid_drop", 128'(S_AXI_BVALID), 128'(1'b0));
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int r_hold,
                          output logic [DW-1:0] data, output logic [1:0] resp);
    bit ar_f, ar_done;
    int cyc, lat;
    logic [DW-1:0] d0;
    ar_done = 0; cyc = 0; lat = 1;
    S_AXI_ARADDR = addr;
    while (!ar_done && cyc < 64) begin
      S_AXI_ARVALID = 1'b1;
      ar_f = S_AXI_ARREADY;
      @(negedge clk);
      ar_done = ar_f;
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    data = 'x; resp = 2'bxx;
    check("rd_handshake", 128'(ar_done), 128'(1'b1));
    if (!ar_done) return;
    while (!S_AXI_RVALID && lat < 20) begin @(negedge clk); lat++; end
    check("r_latency", 128'(lat), 128'(1));
    d0 = S_AXI_RDATA;
    repeat (r_hold) begin
      @(negedge clk);
      check("rvalid_hold", 128'(S_AXI_RVALID), 128'(1'b1));
      check("rdata_hold", 128'(S_AXI_RDATA), 128'(d0));
    end
    S_AXI_RREADY = 1'b1;
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    @(negedge clk);
    S_AXI_RREADY = 1'b0;
    check("rvalid_drop", 128'(S_AXI_RVALID), 128'(1'b0));
  endtask

  // Read and compare against the model in one step.
  task automatic read_cmp(input string tag, input logic [AW-1:0] addr, input int r_hold);
    logic [DW-1:0] d, ed;
    logic [1:0] r, er;
    model_read(addr, ed, er);
    axi_read(addr, r_hold, d, r);
    check({tag, "_rdata"}, 128'(d), 128'(ed));
    check({tag, "_rresp"}, 128'(r), 128'(er));
  endtask

  task automatic write_cmp(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly, input int b_hold);
    logic [1:0] r, er;
    er = model_write(addr, data, strb);
    axi_write(addr, data, strb, aw_dly, w_dly, b_hold, r);
    check({tag, "_bresp"}, 128'(r), 128'(er));
    check({tag, "_ctrl_o"}, ctrl_o, model_ctrl());
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_AWPROT = '0; S_AXI_ARPROT = '0;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    status_i = 32'h1234_5678; irq_src_i = '0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b000));
    check("rst_valid", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b00));
    check("rst_resp", 128'({S_AXI_BRESP, S_AXI_RRESP}), 128'(4'b0000));
    check("rst_rdata", 128'(S_AXI_RDATA), 128'(0));
    check("rst_irq", 128'(irq_o), 128'(1'b0));
    check("rst_ctrl", ctrl_o, model_ctrl());
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ready", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));

    // Write 1..4 into CTRL0..3 and read back
    for (int i = 0; i < NR; i++) write_cmp("t1_wr", 7'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < NR; i++) read_cmp("t1_rd", 7'(i * 4), 0);
    check("t1_ctrl_o", ctrl_o, 128'h00000004_00000003_00000002_00000001);

    // W three cycles ahead of AW, BREADY held off five cycles
    write_cmp("t2_w_first", 7'h04, 32'hA5A5A5A5, 4'hF, 3, 0, 5);
    read_cmp("t2_rd", 7'h04, 3);

    // Byte strobes, and an all-zero strobe
    write_cmp("t3_full", 7'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    write_cmp("t3_strb", 7'h00, 32'h00000000, 4'b0101, 0, 2, 0);
    read_cmp("t3_rd", 7'h00, 0);
    check("t3_value", 128'(m_ctrl[0]), 128'(32'hFF00FF00));
    write_cmp("t3_nostrb", 7'h00, 32'h12345678, 4'h0, 1, 0, 1);
    read_cmp("t3_rd2", 7'h00, 0);

    // Unmapped and STATUS accesses
    read_cmp("t4_unmapped", 7'h40, 0);
    write_cmp("t4_unmapped", 7'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    write_cmp("t4_status", 7'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    status_i = 32'h0BAD_F00D;
    read_cmp("t4_status", 7'h10, 1);

    // Interrupts
    write_cmp("t5_en", 7'h18, 32'h8, 4'hF, 0, 0, 0);
    irq_src_i = 32'h8;
    @(negedge clk);
    irq_src_i = '0;
    m_pend = m_pend | 32'h8;
    check("t5_irq_lag", 128'(irq_o), 128'(1'b0));
    @(negedge clk);
    check("t5_irq_set", 128'(irq_o), 128'(1'b1));
    read_cmp("t5_pend", 7'h14, 0);
    irq_src_i = 32'h8;
    write_cmp("t5_w1c_vs_set", 7'h14, 32'h8, 4'hF, 0, 0, 0);
    irq_src_i = '0;
    m_pend = m_pend | 32'h8;
    read_cmp("t5_pend_kept", 7'h14, 0);
    check("t5_irq_kept", 128'(irq_o), 128'(1'b1));
    write_cmp("t5_w1c", 7'h14, 32'h8, 4'hF, 0, 0, 0);
    check("t5_irq_clr", 128'(irq_o), 128'(1'b0));
    read_cmp("t5_pend_clr", 7'h14, 0);
    irq_src_i = 32'h2;
    @(negedge clk);
    irq_src_i = '0;
    m_pend = m_pend | 32'h2;
    repeat (2) @(negedge clk);
    check("t5_irq_masked", 128'(irq_o), 128'(1'b0));
    write_cmp("t5_w1c_nostrb", 7'h14, 32'h2, 4'b1110, 0, 0, 0);
    read_cmp("t5_pend_nostrb", 7'h14, 0);
    write_cmp("t5_w1c2", 7'h14, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    read_cmp("t5_pend_zero", 7'h14, 0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      logic [AW-1:0] a;
      a = 7'(($urandom_range(0, 9) << 2) | $urandom_range(0, 3));
      status_i = $urandom;
      if ($urandom_range(0, 1) == 1)
        write_cmp("rnd_wr", a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        read_cmp("rnd_rd", a, $urandom_range(0, 2));
    end

    // Reset while AW is held and W is pending
    S_AXI_AWADDR  = 7'h00;
    S_AXI_AWVALID = 1'b1;
    check("t6_awready", 128'(S_AXI_AWREADY), 128'(1'b1));
    @(negedge clk);
    S_AXI_AWVALID = 1'b0;
    check("t6_aw_held", 128'({S_AXI_AWREADY, S_AXI_WREADY}), 128'(2'b01));
    S_AXI_WDATA  = 32'h5555AAAA;
    S_AXI_WSTRB  = 4'hF;
    S_AXI_WVALID = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_ready", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b000));
    check("t6_valid", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b00));
    check("t6_ctrl", ctrl_o, model_ctrl());
    S_AXI_WVALID = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    write_cmp("t6_fresh", 7'h04, 32'hDEADBEEF, 4'hF, 0, 1, 0);
    read_cmp("t6_rd0", 7'h00, 0);
    read_cmp("t6_rd1", 7'h04, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
